// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit, its controller, the instruction ROM and the
// opcode decoder. The fetch unit takes the slave side; the master side is
// whatever drives Start/LUT/condition inputs and supplies ROM data.
interface fetch_unit_if #(
   parameter int PCW = 10
);
   logic           Start;
   logic [PCW-1:0] StartAddr;
   logic [8:0]     InstrIn;
   logic [PCW-1:0] ProgCtr;
   logic [8:0]     Instr;
   logic           InstrValid;
   logic           CondWe;
   logic           CondIn;
   logic           LutWe;
   logic [3:0]     LutAddr;
   logic [PCW-1:0] LutData;
   logic           BranchTaken;
   logic           Running;
   logic           Done;

   modport master (
      output Start, StartAddr, InstrIn, CondWe, CondIn, LutWe, LutAddr, LutData,
      input  ProgCtr, Instr, InstrValid, BranchTaken, Running, Done
   );

   modport slave (
      input  Start, StartAddr, InstrIn, CondWe, CondIn, LutWe, LutAddr, LutData,
      output ProgCtr, Instr, InstrValid, BranchTaken, Running, Done
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / program counter stage. Holds the PC, presents the
// ROM word to the decoder, resolves beq/bne from a registered condition
// flag and an absolute-target LUT, and sequences IDLE -> RUN -> DONE.
module fetch_unit #(
   parameter int PCW  = 10,
   parameter int LUTN = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   fetch_unit_if.slave      bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [8:0] HALT_WORD = 9'b00101_1111;
   localparam logic [4:0] OP_BEQ    = 5'b00101;
   localparam logic [4:0] OP_BNE    = 5'b00110;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [PCW-1:0] r_pc;
   logic [PCW-1:0] w_pc_nxt;
   logic           r_cond;
   logic [PCW-1:0] r_lut [LUTN];

   logic           w_run;
   logic           w_halt;
   logic           w_beq;
   logic           w_bne;
   logic           w_taken;
   logic           w_lut_wr;
   logic [PCW-1:0] w_target;

   // Instruction classification; the halt word shares the beq opcode and is
   // excluded from ordinary beq decoding.
   assign w_run    = (r_state == S_RUN);
   assign w_halt   = (bus.InstrIn == HALT_WORD);
   assign w_beq    = (bus.InstrIn[8:4] == OP_BEQ) && (bus.InstrIn[3:0] != 4'hF);
   assign w_bne    = (bus.InstrIn[8:4] == OP_BNE);
   assign w_taken  = w_run && ((w_beq && r_cond) || (w_bne && !r_cond));
   assign w_target = r_lut[bus.InstrIn[3:0]];
   assign w_lut_wr = bus.LutWe && (r_state != S_RUN);

   // Instr is held at zero outside RUN so the decoder never sees stale ROM data.
   assign bus.ProgCtr     = r_pc;
   assign bus.Instr       = w_run ? bus.InstrIn : 9'd0;
   assign bus.InstrValid  = w_run && !w_halt;
   assign bus.BranchTaken = w_taken;
   assign bus.Running     = w_run;
   assign bus.Done        = (r_state == S_DONE);

   // Next-state and next-PC selection.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.Start) begin
               w_state_nxt = S_RUN;
               w_pc_nxt    = bus.StartAddr;
            end
         end
         S_RUN: begin
            if (w_halt) begin
               w_state_nxt = S_DONE;
            end else if (w_taken) begin
               w_pc_nxt = w_target;
            end else begin
               w_pc_nxt = r_pc + PCW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = '0;
         end
      endcase
   end

   // State and PC registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // Condition flag: only eq/lt executed in RUN update it; it survives restarts.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_cond <= 1'b0;
      end else if (w_run && bus.CondWe) begin
         r_cond <= bus.CondIn;
      end
   end

   // Branch target LUT: writable only while not running.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < LUTN; i++) begin
            r_lut[i] <= '0;
         end
      end else if (w_lut_wr) begin
         r_lut[bus.LutAddr] <= bus.LutData;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: a small ROM model feeds InstrIn from
// ProgCtr, and each step compares outputs against hand-computed values.
module tb_fetch_unit;

   localparam int PCW = 10;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   logic [8:0] rom [1024];

   fetch_unit_if #(.PCW(PCW)) u_if ();

   fetch_unit #(.PCW(PCW), .LUTN(16)) u_dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (u_if)
   );

   assign u_if.InstrIn = rom[u_if.ProgCtr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      u_if.Start     = 1'b0;
      u_if.StartAddr = '0;
      u_if.CondWe    = 1'b0;
      u_if.CondIn    = 1'b0;
      u_if.LutWe     = 1'b0;
      u_if.LutAddr   = 4'd0;
      u_if.LutData   = '0;
   endtask

   task automatic lut_wr(input logic [3:0] a, input logic [PCW-1:0] d);
      u_if.LutWe   = 1'b1;
      u_if.LutAddr = a;
      u_if.LutData = d;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
      rom[10'h013] = 9'h061;   // bne idx1
      rom[10'h021] = 9'h053;   // beq idx3
      rom[10'h041] = 9'h053;   // beq idx3
      rom[10'h042] = 9'h064;   // bne idx4
      rom[10'h033] = 9'h065;   // bne idx5
      rom[10'h034] = 9'h052;   // beq idx2
      rom[10'h005] = 9'h05F;   // halt
      rom[10'h022] = 9'h063;   // bne idx3

      clr_in();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_pc",      32'(u_if.ProgCtr),     32'h000);
      chk("rst_instr",   32'(u_if.Instr),       32'h000);
      chk("rst_valid",   32'(u_if.InstrValid),  32'd0);
      chk("rst_taken",   32'(u_if.BranchTaken), 32'd0);
      chk("rst_running", 32'(u_if.Running),     32'd0);
      chk("rst_done",    32'(u_if.Done),        32'd0);

      // LUT loads in IDLE; the last one shares its cycle with Start.
      lut_wr(4'd1, 10'h020); tick();
      lut_wr(4'd2, 10'h3FF); tick();
      lut_wr(4'd4, 10'h033); tick();
      lut_wr(4'd3, 10'h040);
      u_if.Start = 1'b1; u_if.StartAddr = 10'h010;
      tick(); clr_in();
      chk("run_pc010",   32'(u_if.ProgCtr),     32'h010);
      chk("run_running", 32'(u_if.Running),     32'd1);
      chk("run_valid",   32'(u_if.InstrValid),  32'd1);
      chk("run_taken0",  32'(u_if.BranchTaken), 32'd0);
      chk("run_instr",   32'(u_if.Instr),       32'h000);
      chk("run_done0",   32'(u_if.Done),        32'd0);

      // Start while running must be ignored.
      u_if.Start = 1'b1; u_if.StartAddr = 10'h200;
      tick(); clr_in();
      chk("pc011",       32'(u_if.ProgCtr),     32'h011);
      tick();
      chk("pc012",       32'(u_if.ProgCtr),     32'h012);
      tick();
      chk("bne_instr",   32'(u_if.Instr),       32'h061);
      chk("bne_taken",   32'(u_if.BranchTaken), 32'd1);
      tick();
      chk("bne_tgt",     32'(u_if.ProgCtr),     32'h020);

      u_if.CondWe = 1'b1; u_if.CondIn = 1'b1;
      tick(); clr_in();
      chk("beq_pc",      32'(u_if.ProgCtr),     32'h021);
      chk("beq_taken",   32'(u_if.BranchTaken), 32'd1);
      tick();
      chk("beq_tgt",     32'(u_if.ProgCtr),     32'h040);

      u_if.CondWe = 1'b1; u_if.CondIn = 1'b0;
      tick(); clr_in();
      chk("beqn_taken",  32'(u_if.BranchTaken), 32'd0);
      tick();
      chk("beqn_pc",     32'(u_if.ProgCtr),     32'h042);
      // Same-cycle condition write must not affect this bne.
      u_if.CondWe = 1'b1; u_if.CondIn = 1'b1;
      chk("samecyc_tk",  32'(u_if.BranchTaken), 32'd1);
      tick(); clr_in();
      chk("samecyc_pc",  32'(u_if.ProgCtr),     32'h033);
      chk("newcond_tk",  32'(u_if.BranchTaken), 32'd0);
      // LUT write in RUN must be dropped.
      lut_wr(4'd3, 10'h100);
      tick(); clr_in();
      chk("pc034",       32'(u_if.ProgCtr),     32'h034);
      chk("beq2_taken",  32'(u_if.BranchTaken), 32'd1);
      tick();
      chk("pc3ff",       32'(u_if.ProgCtr),     32'h3FF);
      tick();
      chk("wrap_pc",     32'(u_if.ProgCtr),     32'h000);
      for (int i = 0; i < 5; i++) tick();
      chk("halt_pc",     32'(u_if.ProgCtr),     32'h005);
      chk("halt_valid",  32'(u_if.InstrValid),  32'd0);
      chk("halt_taken",  32'(u_if.BranchTaken), 32'd0);
      tick();
      chk("done_done",   32'(u_if.Done),        32'd1);
      chk("done_run",    32'(u_if.Running),     32'd0);
      chk("done_valid",  32'(u_if.InstrValid),  32'd0);
      chk("done_pc",     32'(u_if.ProgCtr),     32'h005);
      tick();
      chk("done_hold",   32'(u_if.ProgCtr),     32'h005);

      // Restart from DONE: Cond (1) persists and LUT[3] is still 0x040.
      u_if.Start = 1'b1; u_if.StartAddr = 10'h021;
      tick(); clr_in();
      chk("rs_running",  32'(u_if.Running),     32'd1);
      chk("rs_done",     32'(u_if.Done),        32'd0);
      chk("rs_pc",       32'(u_if.ProgCtr),     32'h021);
      chk("rs_taken",    32'(u_if.BranchTaken), 32'd1);
      tick();
      chk("rs_tgt",      32'(u_if.ProgCtr),     32'h040);
      u_if.CondWe = 1'b1; u_if.CondIn = 1'b0;
      tick(); clr_in();
      tick();
      u_if.CondWe = 1'b1; u_if.CondIn = 1'b1;
      tick(); clr_in();
      chk("rs_pc033",    32'(u_if.ProgCtr),     32'h033);

      // Reset mid-RUN with Cond=1.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_pc",       32'(u_if.ProgCtr),     32'h000);
      chk("mr_running",  32'(u_if.Running),     32'd0);
      chk("mr_done",     32'(u_if.Done),        32'd0);
      chk("mr_valid",    32'(u_if.InstrValid),  32'd0);
      u_if.Start = 1'b1; u_if.StartAddr = 10'h021;
      tick(); clr_in();
      chk("mr_cond0",    32'(u_if.BranchTaken), 32'd0);
      tick();
      chk("mr_pc022",    32'(u_if.ProgCtr),     32'h022);
      chk("mr_bne_tk",   32'(u_if.BranchTaken), 32'd1);
      tick();
      chk("mr_lut0",     32'(u_if.ProgCtr),     32'h000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and program-counter stage, directly upstream of the opcode control decoder.
- Holds the PC and drives the instruction-ROM address; passes the 9-bit instruction word to the decoder (opcode = Instr[8:4]).
- Resolves beq/bne using a 1-bit condition flag written by eq/lt results and a 16-entry absolute branch-target LUT.
- Sequences the program with a Start/Done handshake.

Parameters:
PCW, 10, program counter / instruction address width
LUTN, 16, branch target LUT entries (index = Instr[3:0])

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  one-cycle pulse: begin execution at StartAddr
StartAddr  in  PCW  first instruction address
InstrIn  in  9  instruction ROM data, combinational from ProgCtr
ProgCtr  out  PCW  instruction ROM address
Instr  out  9  instruction to control decoder
InstrValid  out  1  Instr is live this cycle; decoder side effects gated by it
CondWe  in  1  write condition flag (eq/lt executed)
CondIn  in  1  eq/lt result from ALU
LutWe  in  1  LUT write enable
LutAddr  in  4  LUT write index
LutData  in  PCW  LUT write data (absolute target)
BranchTaken  out  1  current instruction redirects PC
Running  out  1  high in RUN
Done  out  1  high in DONE

Behaviour:
- One clock; reset is synchronous and active-high: on Clk edge with Reset=1 -> state IDLE, ProgCtr=0, Cond=0, all LUT entries=0. Reset has priority over every other input, including mid-RUN.
- Reset values of outputs: ProgCtr=0, Instr=0, InstrValid=0, BranchTaken=0, Running=0, Done=0.
- States: IDLE, RUN, DONE.
  - IDLE: Start=1 -> ProgCtr<=StartAddr, go RUN.
  - RUN: each cycle, one instruction is fetched and presented; ProgCtr updates at the edge.
  - Halt (Instr==9'b00101_1111, beq with LUT index 15) -> DONE; ProgCtr holds at the halt address.
  - DONE: Done=1; Start=1 -> ProgCtr<=StartAddr, go RUN (restart).
  - Start in RUN is ignored.
- Instr = InstrIn combinationally; InstrValid = Running & ~halt. Halt is never valid to the decoder.
- Next PC in RUN:
  - beq (00101, index!=15): taken iff Cond==1.
  - bne (00110): taken iff Cond==0.
  - Taken -> ProgCtr <= LUT[Instr[3:0]]; otherwise ProgCtr <= ProgCtr+1, modulo 2^PCW (max wraps to 0, no flag).
- BranchTaken is combinational, asserted only in RUN for a taken beq/bne; it is 0 for halt.
- Cond flag: CondWe=1 -> Cond<=CondIn at the edge. Branches use the registered Cond, so a CondWe in the same cycle as a branch does not affect that branch (new value is visible next cycle). CondWe is ignored outside RUN; Cond persists across DONE->RUN restart.
- LUT writes are accepted only in IDLE or DONE (Cond-independent, one entry per cycle). LutWe in RUN is ignored. A write and a Start in the same cycle both take effect; the write is visible to the first branch.
- Single-cycle fetch, no stalls; latency Start -> first InstrValid = 1 cycle.

Test Plan:
- Reset then Start with StartAddr=0x010, ROM of adds (00000_xxxx) -> ProgCtr 0x010,0x011,0x012 on consecutive cycles, InstrValid=1, BranchTaken=0.
- Load LUT[3]=0x040; CondWe=1,CondIn=1 at PC 0x020, beq idx3 at 0x021 -> BranchTaken=1, next ProgCtr=0x040. Repeat with CondIn=0 -> ProgCtr=0x022.
- bne idx3 with Cond=0 -> ProgCtr=0x040. Same-cycle CondWe=1,CondIn=1 with bne at PC -> branch still taken using old Cond=0; Cond reads 1 on the following cycle.
- StartAddr=0x3FF, add at 0x3FF -> ProgCtr wraps to 0x000. Halt word 9'b001011111 at 0x005 -> Done=1, Running=0, InstrValid=0, ProgCtr holds 0x005; Start -> RUN at StartAddr.
- LutWe during RUN (LutAddr=3, data 0x100) -> LUT[3] unchanged (branch still to 0x040). Reset asserted mid-RUN at PC 0x033 -> next cycle IDLE, ProgCtr=0, Cond=0, LUT[3]=0.
